if_id_pipe_reg: RTL and testbench
=================================

# if_id_pipe_reg

IF/ID pipeline register and stall/flush sequencer on the consumer side of the load-use hazard interface. Each cycle it captures the fetched PC and instruction, holds them while `if_id_write` is low, and replaces them with a NOP bubble on a taken jump/branch flush. It also exposes the decoded `rs1`/`rs2` fields that the hazard detector compares against `rd_ex`.

## Interface
Parameters:
- `PC_W`, 64, program counter width
- `INSTR_W`, 32, instruction width, fixed at 32 for RV encoding
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  in  1  rising-edge clock
- `arst_n`  in  1  asynchronous active-low reset
- `en`  in  1  global pipeline enable; low freezes all state
- `if_id_write`  in  1  from hazard detection; 0 = hold current contents
- `flush`  in  1  taken branch/jump resolved; squash the IF-stage instruction
- `pc_if`  in  PC_W  fetch-stage PC
- `instr_if`  in  32  fetch-stage instruction
- `pc_id`  out  PC_W  registered PC
- `instr_id`  out  32  registered instruction
- `valid_id`  out  1  1 = `instr_id` is a real instruction, 0 = bubble
- `rs1_id`  out  5  `instr_id[19:15]`, forced to 0 when `valid_id`=0
- `rs2_id`  out  5  `instr_id[24:20]`, forced to 0 when `valid_id`=0
- `state_id`  out  2  FSM state (00 RUN, 01 HOLD, 10 BUBBLE)
- `stall_cycles`  out  32  perf counter (see Configuration)
- `flush_count`  out  32  perf counter (see Configuration)

## Operation
- FSM states:
  - RUN: last edge loaded `pc_if`/`instr_if`.
  - HOLD: last edge held the contents because of a stall.
  - BUBBLE: last edge loaded a NOP because of a flush.
- Evaluation at each rising edge with `en`=1, in priority order:
  1. `flush`=1: `instr_id`←`NOP_INSTR`, `pc_id`←`pc_if`, `valid_id`←0, state←BUBBLE. Flush wins over a simultaneous stall.
  2. `if_id_write`=0: all registers hold, state←HOLD. `valid_id` is unchanged, so a held bubble stays a bubble.
  3. Otherwise: load `pc_if`/`instr_if`, `valid_id`←1, state←RUN.
- `en`=0: no register changes, including the perf counters. FSM state is unchanged.
- `rs1_id`/`rs2_id` are combinational from the registered instruction, gated by `valid_id`. A bubble therefore never presents a non-zero source register to the hazard unit.
- Reset (async, any cycle, including mid-stall):
  - `pc_id`=0, `instr_id`=`NOP_INSTR`, `valid_id`=0, state=BUBBLE.
  - `rs1_id`=`rs2_id`=0, `stall_cycles`=0, `flush_count`=0.
- Reset release: the first enabled edge follows the normal priority rules.

## Timing
- Latency is one cycle from `pc_if`/`instr_if` to `pc_id`/`instr_id`.
- A stall asserted in cycle N holds the value loaded at edge N-1 through every edge while `if_id_write`=0. The IF value present on the first edge after `if_id_write` returns to 1 is loaded.
- A flush in cycle N gives `valid_id`=0 from edge N until the next load edge.
- `rs1_id`/`rs2_id` change in the same cycle as `instr_id` and have no extra register stage. This meets the hazard unit's combinational compare within one cycle.
- There are no combinational paths from the inputs to any output.

## Configuration
- Macro `IF_ID_PERF_EN`.
- Defined:
  - `stall_cycles` increments on each enabled edge taking the HOLD branch.
  - `flush_count` increments on each enabled edge taking the flush branch.
  - Both counters saturate at 32'hFFFF_FFFF and do not wrap.
- Undefined:
  - Both counter outputs are tied to 0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Reset mid-operation: with `valid_id`=1, assert `arst_n`=0 between edges. Outputs change immediately to `instr_id`=0x00000013, `valid_id`=0, `pc_id`=0, `state_id`=10, counters=0.
- Normal flow: `pc_if`=0x100 with `instr_if`=0x00A28293, then `pc_if`=0x104. Each appears on `pc_id`/`instr_id` one edge later, with `valid_id`=1 and `rs1_id`=5.
- Load-use stall: `if_id_write`=0 for 2 edges while `pc_if` changes 0x108→0x10C. `pc_id` stays 0x104 and `state_id`=01; the next edge with `if_id_write`=1 loads the current `pc_if`. `stall_cycles`=2 with `IF_ID_PERF_EN` defined, 0 without.
- Simultaneous `flush`=1 and `if_id_write`=0 with `pc_if`=0x200: `instr_id`=0x00000013, `valid_id`=0, `rs1_id`=`rs2_id`=0, `state_id`=10, `flush_count`=1.
- Stall of a bubble: flush, then `if_id_write`=0 for 3 edges. `valid_id` stays 0 and `instr_id` stays NOP.
- `en`=0 while toggling `flush` and `if_id_write`: no output or counter changes.
- Counter saturation: preload or force `stall_cycles` to 0xFFFF_FFFE, then 3 stall edges. The counter reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall/flush sequencing and gated rs1/rs2 fields for the hazard unit.
// Optional perf counters are enabled by defining IF_ID_PERF_EN.
module if_id_pipe_reg #(
  parameter int unsigned       PC_W      = 64,
  parameter int unsigned       INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               en,
  input  logic               if_id_write,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc_if,
  input  logic [INSTR_W-1:0] instr_if,
  output logic [PC_W-1:0]    pc_id,
  output logic [INSTR_W-1:0] instr_id,
  output logic               valid_id,
  output logic [4:0]         rs1_id,
  output logic [4:0]         rs2_id,
  output logic [1:0]         state_id,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HOLD   = 2'b01,
    BUBBLE = 2'b10
  } state_e;

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // Flush outranks a stall so a squashed instruction can never be held in ID.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= BUBBLE;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (en) begin
      if (flush) begin
        state_q <= BUBBLE;
        pc_q    <= pc_if;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (!if_id_write) begin
        state_q <= HOLD;
      end else begin
        state_q <= RUN;
        pc_q    <= pc_if;
        instr_q <= instr_if;
        valid_q <= 1'b1;
      end
    end
  end

  assign pc_id    = pc_q;
  assign instr_id = instr_q;
  assign valid_id = valid_q;
  assign state_id = state_q;

  // Bubbles present x0 so the hazard compare never matches on a squashed slot.
  assign rs1_id = valid_q ? instr_q[19:15] : 5'd0;
  assign rs2_id = valid_q ? instr_q[24:20] : 5'd0;

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (en) begin
      if (flush) begin
        if (flush_count_q != 32'hFFFF_FFFF) flush_count_d = flush_count_q + 32'd1;
      end else if (!if_id_write) begin
        if (stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg; expected counter values follow IF_ID_PERF_EN.
module tb_if_id_pipe_reg;

  localparam int unsigned PC_W = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] I_A  = 32'h00A2_8293; // rs1=5 rs2=10
  localparam logic [31:0] I_B  = 32'h00B3_0313; // rs1=6 rs2=11

  logic            clk = 1'b0;
  logic            arst_n;
  logic            en;
  logic            if_id_write;
  logic            flush;
  logic [PC_W-1:0] pc_if;
  logic [31:0]     instr_if;
  logic [PC_W-1:0] pc_id;
  logic [31:0]     instr_id;
  logic            valid_id;
  logic [4:0]      rs1_id;
  logic [4:0]      rs2_id;
  logic [1:0]      state_id;
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_count;

  int errors = 0;
  int checks = 0;

`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_id_pipe_reg dut (
    .clk(clk), .arst_n(arst_n), .en(en), .if_id_write(if_id_write), .flush(flush),
    .pc_if(pc_if), .instr_if(instr_if), .pc_id(pc_id), .instr_id(instr_id),
    .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .state_id(state_id),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
    return PERF ? v : 32'd0;
  endfunction

  task automatic test_reset();
    arst_n = 1'b0; en = 1'b0; if_id_write = 1'b1; flush = 1'b0;
    pc_if = '0; instr_if = '0;
    #12;
    checks++; if (pc_id !== 64'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_id); end
    checks++; if (instr_id !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr_id, NOP); end
    checks++; if (valid_id !== 1'b0 || state_id !== 2'b10) begin errors++; $display("FAIL reset_vs got=%b/%b exp=0/10", valid_id, state_id); end
    checks++; if (rs1_id !== 5'd0 || rs2_id !== 5'd0) begin errors++; $display("FAIL reset_rs got=%0d/%0d exp=0/0", rs1_id, rs2_id); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
    #2 arst_n = 1'b1;
    step();
  endtask

  task automatic test_normal();
    en = 1'b1; if_id_write = 1'b1; flush = 1'b0;
    pc_if = 64'h100; instr_if = I_A;
    step();
    checks++; if (pc_id !== 64'h100 || instr_id !== I_A) begin errors++; $display("FAIL norm0_load got=%h/%h exp=100/%h", pc_id, instr_id, I_A); end
    checks++; if (valid_id !== 1'b1 || state_id !== 2'b00) begin errors++; $display("FAIL norm0_vs got=%b/%b exp=1/00", valid_id, state_id); end
    checks++; if (rs1_id !== 5'd5 || rs2_id !== 5'd10) begin errors++; $display("FAIL norm0_rs got=%0d/%0d exp=5/10", rs1_id, rs2_id); end
    pc_if = 64'h104; instr_if = I_B;
    step();
    checks++; if (pc_id !== 64'h104 || instr_id !== I_B) begin errors++; $display("FAIL norm1_load got=%h/%h exp=104/%h", pc_id, instr_id, I_B); end
    checks++; if (rs1_id !== 5'd6 || rs2_id !== 5'd11) begin errors++; $display("FAIL norm1_rs got=%0d/%0d exp=6/11", rs1_id, rs2_id); end
  endtask

  task automatic test_stall();
    if_id_write = 1'b0; pc_if = 64'h108; instr_if = I_A;
    step();
    checks++; if (pc_id !== 64'h104 || state_id !== 2'b01 || valid_id !== 1'b1) begin errors++; $display("FAIL stall0 got=%h/%b/%b exp=104/01/1", pc_id, state_id, valid_id); end
    pc_if = 64'h10C;
    step();
    checks++; if (pc_id !== 64'h104 || instr_id !== I_B) begin errors++; $display("FAIL stall1 got=%h/%h exp=104/%h", pc_id, instr_id, I_B); end
    checks++; if (stall_cycles !== perf(32'd2)) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cycles, perf(32'd2)); end
    if_id_write = 1'b1; pc_if = 64'h110; instr_if = I_A;
    step();
    checks++; if (pc_id !== 64'h110 || instr_id !== I_A || state_id !== 2'b00) begin errors++; $display("FAIL stall_rel got=%h/%h/%b exp=110/%h/00", pc_id, instr_id, state_id, I_A); end
  endtask

  task automatic test_flush_over_stall();
    flush = 1'b1; if_id_write = 1'b0; pc_if = 64'h200; instr_if = I_B;
    step();
    checks++; if (instr_id !== NOP || valid_id !== 1'b0 || pc_id !== 64'h200) begin errors++; $display("FAIL fls_load got=%h/%b/%h exp=%h/0/200", instr_id, valid_id, pc_id, NOP); end
    checks++; if (rs1_id !== 5'd0 || rs2_id !== 5'd0 || state_id !== 2'b10) begin errors++; $display("FAIL fls_rs got=%0d/%0d/%b exp=0/0/10", rs1_id, rs2_id, state_id); end
    checks++; if (flush_count !== perf(32'd1) || stall_cycles !== perf(32'd2)) begin errors++; $display("FAIL fls_cnt got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles, perf(32'd1), perf(32'd2)); end
  endtask

  task automatic test_hold_bubble();
    flush = 1'b1; if_id_write = 1'b1; pc_if = 64'h204; instr_if = I_A;
    step();
    flush = 1'b0; if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_if = 64'h208 + 64'(4 * i);
      step();
      checks++; if (valid_id !== 1'b0 || instr_id !== NOP || pc_id !== 64'h204 || state_id !== 2'b01) begin errors++; $display("FAIL hold_bub%0d got=%b/%h/%h/%b exp=0/%h/204/01", i, valid_id, instr_id, pc_id, state_id, NOP); end
    end
    checks++; if (stall_cycles !== perf(32'd5) || flush_count !== perf(32'd2)) begin errors++; $display("FAIL hold_cnt got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, perf(32'd5), perf(32'd2)); end
  endtask

  task automatic test_en_low();
    en = 1'b0; pc_if = 64'h300; instr_if = I_A;
    for (int i = 0; i < 4; i++) begin
      flush = i[0]; if_id_write = i[1];
      step();
      checks++; if (pc_id !== 64'h204 || instr_id !== NOP || valid_id !== 1'b0 || state_id !== 2'b01) begin errors++; $display("FAIL en_low%0d got=%h/%h/%b/%b exp=204/%h/0/01", i, pc_id, instr_id, valid_id, state_id, NOP); end
      checks++; if (stall_cycles !== perf(32'd5) || flush_count !== perf(32'd2)) begin errors++; $display("FAIL en_low_cnt%0d got=%0d/%0d exp=%0d/%0d", i, stall_cycles, flush_count, perf(32'd5), perf(32'd2)); end
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; flush = 1'b0; if_id_write = 1'b1; pc_if = 64'h300; instr_if = I_A;
    step();
    pc_if = 64'h304; instr_if = I_B;
    step();
    checks++; if (pc_id !== 64'h304 || rs1_id !== 5'd6 || valid_id !== 1'b1) begin errors++; $display("FAIL b2b got=%h/%0d/%b exp=304/6/1", pc_id, rs1_id, valid_id); end
  endtask

  task automatic test_reset_mid();
    if_id_write = 1'b0;
    step();
    #2 arst_n = 1'b0;
    #1;
    checks++; if (pc_id !== 64'd0 || instr_id !== NOP || valid_id !== 1'b0 || state_id !== 2'b10) begin errors++; $display("FAIL rst_mid got=%h/%h/%b/%b exp=0/%h/0/10", pc_id, instr_id, valid_id, state_id, NOP); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0 || rs1_id !== 5'd0) begin errors++; $display("FAIL rst_mid_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cycles, flush_count, rs1_id); end
    #2 arst_n = 1'b1;
    if_id_write = 1'b1; pc_if = 64'h400; instr_if = I_A;
    step();
    checks++; if (pc_id !== 64'h400 || valid_id !== 1'b1 || state_id !== 2'b00) begin errors++; $display("FAIL rst_rel got=%h/%b/%b exp=400/1/00", pc_id, valid_id, state_id); end
  endtask

  task automatic test_saturation();
`ifdef IF_ID_PERF_EN
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
`endif
    if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (stall_cycles !== perf(32'hFFFF_FFFF)) begin errors++; $display("FAIL sat got=%h exp=%h", stall_cycles, perf(32'hFFFF_FFFF)); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_flush_over_stall();
    test_hold_bubble();
    test_en_low();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
